// File: rtl/alu_muldiv_seq.sv
// Iterative 32x32 unsigned multiply / restoring divide sequencer.
// Drives the external combinational ALU with one ADD or SUB per cycle and
// folds its result into a 64-bit shifting accumulator {acc_hi, acc_lo}.
module alu_muldiv_seq (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] Result_Hi,
    output logic [31:0] Result_Lo,
    output logic [3:0]  AluControl,
    output logic [31:0] AluInput1,
    output logic [31:0] AluInput2,
    input  logic [31:0] AluOut
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // S_DZERO is the single non-busy cycle between accepting a divide by
    // zero and raising Done, so that case reports two edges after accept.
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DZERO, S_DONE} state_t;

    state_t      state;
    logic [31:0] acc_hi, acc_lo, m;
    logic [4:0]  cnt;

    logic [32:0] rem_sh;
    logic [31:0] mul_sum;
    logic        mul_carry, div_ge;
    logic [31:0] nxt_hi, nxt_lo;

    // ALU drive: depends only on registered state, AluOut returns same cycle
    always_comb begin
        AluControl = ALU_ADD;
        AluInput1  = '0;
        AluInput2  = '0;
        case (state)
            S_MUL: begin
                AluInput1 = acc_hi;
                AluInput2 = m;
            end
            S_DIV: begin
                AluControl = ALU_SUB;
                AluInput1  = rem_sh[31:0];
                AluInput2  = m;
            end
            default: ;
        endcase
    end

    // One iteration step; carry and compare are local, only the sum/diff
    // comes from the ALU
    always_comb begin
        rem_sh    = {acc_hi, acc_lo[31]};
        mul_sum   = acc_lo[0] ? AluOut : acc_hi;
        mul_carry = acc_lo[0] & (AluOut < acc_hi);
        div_ge    = rem_sh[32] | (rem_sh[31:0] >= m);
        if (state == S_DIV) begin
            nxt_hi = div_ge ? AluOut : rem_sh[31:0];
            nxt_lo = {acc_lo[30:0], div_ge};
        end else begin
            nxt_hi = {mul_carry, mul_sum[31:1]};
            nxt_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // Sequencer FSM with registered status and result outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            acc_hi    <= '0;
            acc_lo    <= '0;
            m         <= '0;
            cnt       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Result_Hi <= '0;
            Result_Lo <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        m         <= B;
                        acc_hi    <= '0;
                        acc_lo    <= A;
                        cnt       <= 5'd31;
                        DivByZero <= 1'b0;
                        if (Op && (B == '0)) begin
                            state <= S_DZERO;
                        end else begin
                            state <= Op ? S_DIV : S_MUL;
                            Busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (cnt == 5'd0) begin
                        state     <= S_DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        Result_Hi <= nxt_hi;
                        Result_Lo <= nxt_lo;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_DZERO: begin
                    state     <= S_DONE;
                    Done      <= 1'b1;
                    DivByZero <= 1'b1;
                    Result_Hi <= acc_lo;
                    Result_Lo <= '1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: combinational ALU model, directed table,
// randomized ops against an arithmetic reference, and corner sequences.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dbz;
    logic [31:0] res_hi, res_lo;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_in1, alu_in2, alu_out;

    int nvec = 0;
    int nmis = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    always #5 clk = ~clk;

    // ALU the sequencer drives
    always_comb begin
        case (alu_ctl)
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0110: alu_out = alu_in1 - alu_in2;
            default: alu_out = '0;
        endcase
    end

    alu_muldiv_seq dut (
        .Clock(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b),
        .Busy(busy), .Done(done), .DivByZero(dbz),
        .Result_Hi(res_hi), .Result_Lo(res_lo),
        .AluControl(alu_ctl), .AluInput1(alu_in1), .AluInput2(alu_in2),
        .AluOut(alu_out)
    );

    typedef struct {
        string       name;
        bit          op;
        logic [31:0] a, b, hi, lo;
        bit          dz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input bit mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        logic [63:0] p;
        dz = 1'b0;
        if (!mop) begin
            p  = 64'(ma) * 64'(mb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (mb == 32'd0) begin
            hi = ma;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            hi = ma % mb;
            lo = ma / mb;
        end
    endtask

    // Called at a negedge with the DUT idle or in its Done cycle; returns at
    // the negedge where Done is seen. poke>0 pulses Start mid-operation.
    task automatic do_op(input string name, input bit vop, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit edz, input int poke);
        int   n;
        bit   bad;
        logic [3:0] ectl;
        ectl  = (vop && vb != 0) ? 4'b0110 : 4'b0010;
        start = 1'b1; op = vop; a = va; b = vb;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n = 1; bad = 1'b0;
        while (!done && n < 40) begin
            if (n == poke) begin
                start = 1'b1; op = ~vop; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy !== !edz || alu_ctl !== ectl || dbz !== 1'b0 ||
                res_hi !== last_hi || res_lo !== last_lo)
                bad = 1'b1;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk($sformatf("%s.latency", name), 64'(n), edz ? 64'd2 : 64'd33);
        chk($sformatf("%s.during", name), 64'(bad), 64'd0);
        chk($sformatf("%s.result", name), {res_hi, res_lo}, {ehi, elo});
        chk($sformatf("%s.dbz_busy", name), {62'd0, dbz, busy}, {62'd0, edz, 1'b0});
        last_hi = ehi;
        last_lo = elo;
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] rhi, rlo, ra, rb;
        bit          rdz, rop;

        tbl[0] = '{"mul3x5",   1'b0, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0};
        tbl[1] = '{"mulmax",   1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001,  1'b0};
        tbl[2] = '{"div100_7", 1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        tbl[3] = '{"divmax_1", 1'b1, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  1'b0};
        tbl[4] = '{"div5_0",   1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1'b1};
        tbl[5] = '{"mul0",     1'b0, 32'd0,         32'h12345678,  32'd0,         32'd0,         1'b0};
        tbl[6] = '{"div7_100", 1'b1, 32'd7,         32'd100,       32'd7,         32'd0,         1'b0};
        tbl[7] = '{"divhalf3", 1'b1, 32'h80000000,  32'd3,         32'd2,         32'h2AAAAAAA,  1'b0};
        tbl[8] = '{"divmaxmx", 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd1,         1'b0};
        tbl[9] = '{"mul64k",   1'b0, 32'h00010000,  32'h00010000,  32'd1,         32'd0,         1'b0};

        // reset state
        #12;
        chk("reset.status", {61'd0, busy, done, dbz}, 64'd0);
        chk("reset.result", {res_hi, res_lo}, 64'd0);
        chk("reset.alu", {alu_ctl, alu_in1, alu_in2}, {4'b0010, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table, each op started in the previous op's Done cycle
        foreach (tbl[i])
            do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].dz, -1);
        @(negedge clk);
        chk("idle.done_low", {62'd0, done, busy}, 64'd0);
        chk("idle.hold", {res_hi, res_lo}, {last_hi, last_lo});

        // randomized ops against the arithmetic reference
        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            model(rop, ra, rb, rhi, rlo, rdz);
            do_op($sformatf("rand%0d", i), rop, ra, rb, rhi, rlo, rdz, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Start pulsed at iteration 10 is ignored
        @(negedge clk);
        model(1'b0, 32'd1234, 32'd5678, rhi, rlo, rdz);
        do_op("ignore_mid", 1'b0, 32'd1234, 32'd5678, rhi, rlo, rdz, 10);
        model(1'b1, 32'hDEADBEEF, 32'd1000, rhi, rlo, rdz);
        do_op("ignore_div", 1'b1, 32'hDEADBEEF, 32'd1000, rhi, rlo, rdz, 10);

        // reset mid-operation at iteration 20
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd999; b = 32'd777;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.status", {61'd0, busy, done, dbz}, 64'd0);
        chk("abort.result", {res_hi, res_lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("abort.no_done", {62'd0, done, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        do_op("post_reset", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
